// File: rtl/regfile_dump_ctrl.sv
// Borrows the register-file rs port to stream every register out over valid/ready after a fixed halt/drain window.
// Latency: first word DRAIN_CYCLES+2 cycles after the request, then one word per 2 cycles; a stalled word holds until ready.
module regfile_dump_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dump_req,
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [DATA_W-1:0] i_rf_data_1,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_rf_rs,
  output logic              o_halt,
  output logic              o_busy,
  output logic              o_dump_valid,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [ADDR_W-1:0] o_dump_idx,
  output logic              o_dump_done
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  drain_cnt;

  // Port ownership follows the state directly so an async reset hands rs back to the pipeline at once.
  assign o_rf_rs = (state == READ || state == SEND) ? idx : i_id_rs;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      idx          <= '0;
      drain_cnt    <= '0;
      o_halt       <= 1'b0;
      o_busy       <= 1'b0;
      o_dump_valid <= 1'b0;
      o_dump_data  <= '0;
      o_dump_idx   <= '0;
      o_dump_done  <= 1'b0;
    end else begin
      o_dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_dump_req) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
            idx       <= '0;
            o_halt    <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= READ;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        READ: begin
          o_dump_data  <= i_rf_data_1;
          o_dump_idx   <= idx;
          o_dump_valid <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (i_dump_ready) begin
            o_dump_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state       <= DONE;
              o_halt      <= 1'b0;
              o_dump_done <= 1'b1;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          idx    <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: a register-file stub answers the rs port, a queue holds the expected dump words.
module tb_regfile_dump_ctrl;

  localparam int NUM_REGS = 32;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_dump_req;
  logic [4:0]  i_id_rs;
  logic [31:0] i_rf_data_1;
  logic        i_dump_ready;
  logic [4:0]  o_rf_rs;
  logic        o_halt;
  logic        o_busy;
  logic        o_dump_valid;
  logic [31:0] o_dump_data;
  logic [4:0]  o_dump_idx;
  logic        o_dump_done;

  always #5 i_clk = ~i_clk;

  logic [31:0] rf [NUM_REGS];
  assign i_rf_data_1 = rf[o_rf_rs];

  regfile_dump_ctrl #(
    .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .DRAIN_CYCLES(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dump_req(i_dump_req), .i_id_rs(i_id_rs),
    .i_rf_data_1(i_rf_data_1), .i_dump_ready(i_dump_ready), .o_rf_rs(o_rf_rs),
    .o_halt(o_halt), .o_busy(o_busy), .o_dump_valid(o_dump_valid),
    .o_dump_data(o_dump_data), .o_dump_idx(o_dump_idx), .o_dump_done(o_dump_done)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [4:0] id_rs;
    logic       req;
    logic       ready;
    logic [4:0] exp_rs;
    logic       exp_halt;
    logic       exp_busy;
    logic       exp_valid;
  } vec_t;

  word_t      exp_q[$];
  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         words = 0;
  int         dones = 0;
  int         last_acc_cyc = -1;
  logic [4:0] last_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs are final here, so a visible valid&&ready is the handshake the next edge takes.
  task automatic step();
    word_t e;
    if (i_reset && o_dump_valid && i_dump_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: actual idx %0d, required no word", o_dump_idx);
      end else begin
        e = exp_q.pop_front();
        chk("word_idx", o_dump_idx, e.idx);
        chk("word_data", o_dump_data, e.data);
      end
      words++;
      last_idx     = o_dump_idx;
      last_acc_cyc = cyc + 1;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_dump_done) dones++;
  endtask

  task automatic push_dump(input bit wb10);
    word_t w;
    for (int i = 0; i < NUM_REGS; i++) begin
      w.idx  = 5'(i);
      w.data = (wb10 && i == 10) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
      exp_q.push_back(w);
    end
  endtask

  task automatic request();
    i_dump_req = 1'b1;
    push_dump(1'b0);
    step();
    i_dump_req = 1'b0;
    chk("halt_rise", o_halt, 1'b1);
  endtask

  task automatic run_dump(input int stall_idx, input int req_idx, input int rst_idx, input bit chk_spacing);
    int last_rise = -1;
    int stalled   = 0;
    bit prev_v;
    bit req_done  = 1'b0;
    bit fin       = 1'b0;
    prev_v = o_dump_valid;
    if (prev_v) last_rise = cyc;
    for (int n = 0; n < 400 && !fin; n++) begin
      i_dump_ready = 1'b1;
      if (o_dump_valid) chk("rf_rs_owned", o_rf_rs, o_dump_idx);
      if (stalled > 0 && stalled <= 5) begin
        chk("stall_valid", o_dump_valid, 1'b1);
        chk("stall_idx", o_dump_idx, 5'(stall_idx));
        chk("stall_data", o_dump_data, 32'hA000_0000 + 32'(stall_idx));
        if (stalled == 5) stalled = 6;
      end
      if (o_dump_valid && int'(o_dump_idx) == stall_idx && stalled < 5) begin
        i_dump_ready = 1'b0;
        stalled++;
      end
      if (req_idx >= 0 && !req_done && o_dump_valid && int'(o_dump_idx) == req_idx) begin
        i_dump_req = 1'b1;
        req_done   = 1'b1;
      end
      if (rst_idx >= 0 && o_dump_valid && int'(o_dump_idx) == rst_idx) begin
        #2 i_reset = 1'b0;
        #1;
        chk("rst_halt", o_halt, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_valid", o_dump_valid, 1'b0);
        chk("rst_rf_rs", o_rf_rs, i_id_rs);
        exp_q.delete();
        fin = 1'b1;
      end else begin
        step();
        i_dump_req = 1'b0;
        if (chk_spacing && o_dump_valid && !prev_v) begin
          if (last_rise >= 0) chk("word_spacing", cyc - last_rise, 2);
          last_rise = cyc;
        end
        prev_v = o_dump_valid;
        if (o_dump_done) begin
          chk("done_after_last_accept", cyc, last_acc_cyc);
          chk("done_last_idx", last_idx, 5'd31);
          chk("done_halt_low", o_halt, 1'b0);
          chk("done_busy_high", o_busy, 1'b1);
          chk("done_rf_rs", o_rf_rs, i_id_rs);
          step();
          chk("post_done_busy", o_busy, 1'b0);
          chk("post_done_pulse", o_dump_done, 1'b0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: actual no done after 400 cycles, required done pulse");
    end
  endtask

  initial begin
    i_reset      = 1'b0;
    i_dump_req   = 1'b0;
    i_dump_ready = 1'b0;
    i_id_rs      = 5'd7;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'hA000_0000 + 32'(i);

    step();
    step();
    chk("reset_rf_rs", o_rf_rs, 5'd7);
    chk("reset_halt", o_halt, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_valid", o_dump_valid, 1'b0);
    chk("reset_data", o_dump_data, 32'h0);
    chk("reset_idx", o_dump_idx, 5'd0);
    chk("reset_done", o_dump_done, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;

    // Idle pass-through, then the request and every cycle up to the first word.
    vecs[0] = '{5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd3,  1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd31, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd7,  1'b1, 1'b1, 5'd7,  1'b1, 1'b1, 1'b0};
    vecs[4] = '{5'd9,  1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0};
    vecs[5] = '{5'd9,  1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0};
    vecs[6] = '{5'd9,  1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0};
    vecs[7] = '{5'd9,  1'b0, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0};
    vecs[8] = '{5'd9,  1'b0, 1'b1, 5'd0,  1'b1, 1'b1, 1'b1};
    words = 0;
    dones = 0;
    for (int i = 0; i < 9; i++) begin
      i_id_rs      = vecs[i].id_rs;
      i_dump_req   = vecs[i].req;
      i_dump_ready = vecs[i].ready;
      if (vecs[i].req) push_dump(1'b0);
      step();
      i_dump_req = 1'b0;
      chk($sformatf("vec%0d_rf_rs", i), o_rf_rs, vecs[i].exp_rs);
      chk($sformatf("vec%0d_halt", i), o_halt, vecs[i].exp_halt);
      chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_valid", i), o_dump_valid, vecs[i].exp_valid);
    end
    i_id_rs = 5'd17;
    run_dump(-1, -1, -1, 1'b1);
    chk("full_words", words, 32);
    chk("full_dones", dones, 1);
    chk("full_queue_empty", exp_q.size(), 0);

    // Backpressure on idx 3.
    words = 0;
    dones = 0;
    request();
    run_dump(3, -1, -1, 1'b0);
    chk("bp_words", words, 32);
    chk("bp_dones", dones, 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Write-back landing during the drain window.
    words = 0;
    dones = 0;
    i_dump_req = 1'b1;
    step();
    i_dump_req = 1'b0;
    step();
    chk("wb_in_drain_halt", o_halt, 1'b1);
    chk("wb_in_drain_valid", o_dump_valid, 1'b0);
    rf[10] = 32'hDEAD_BEEF;
    push_dump(1'b1);
    run_dump(-1, -1, -1, 1'b1);
    rf[10] = 32'hA000_000A;
    chk("wb_words", words, 32);
    chk("wb_queue_empty", exp_q.size(), 0);

    // A request while busy must be dropped.
    words = 0;
    dones = 0;
    request();
    run_dump(-1, 12, -1, 1'b1);
    chk("busy_req_words", words, 32);
    chk("busy_req_dones", dones, 1);
    repeat (6) step();
    chk("busy_req_idle_busy", o_busy, 1'b0);
    chk("busy_req_idle_halt", o_halt, 1'b0);
    chk("busy_req_no_second_done", dones, 1);

    // Reset mid-dump, then restart from idx 0.
    words = 0;
    dones = 0;
    request();
    run_dump(-1, -1, 20, 1'b0);
    chk("rst_words", words, 20);
    step();
    step();
    chk("rst_data", o_dump_data, 32'h0);
    chk("rst_idx", o_dump_idx, 5'd0);
    chk("rst_no_done", dones, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    words = 0;
    dones = 0;
    request();
    run_dump(-1, -1, -1, 1'b1);
    chk("restart_words", words, 32);
    chk("restart_dones", dones, 1);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
